// File: rtl/smoldvi_tmds_encoder_if.sv
// ---------------------------------------------------------------------------
// smoldvi_tmds_encoder_if
//
// Pixel-side bundle for one TMDS channel encoder.
//   den   : data enable (1 = encode data, 0 = emit control symbol for c)
//   data  : 8-bit pixel component
//   c     : 2-bit control word, c[0] = C0
//   q     : 10-bit TMDS symbol, q[0] is the first bit on the wire
//
// Modports:
//   master : the pixel source (drives den/data/c, observes q)
//   slave  : the encoder (consumes den/data/c, drives q)
// ---------------------------------------------------------------------------
interface smoldvi_tmds_encoder_if;
    logic       den;
    logic [7:0] data;
    logic [1:0] c;
    logic [9:0] q;

    modport master (
        output den,
        output data,
        output c,
        input  q
    );

    modport slave (
        input  den,
        input  data,
        input  c,
        output q
    );
endinterface

// File: rtl/smoldvi_tmds_encoder.sv
// ---------------------------------------------------------------------------
// smoldvi_tmds_encoder
//
// DVI 1.0 TMDS encoder for one channel. Two-stage pipeline:
//   stage 1 : transition minimisation (XOR / XNOR chain) -> qm
//   stage 2 : DC balance against the running disparity cnt -> q
// A control symbol is emitted whenever den was low; that also clears cnt.
// Latency is two clk_in edges for both data and control, one symbol per
// cycle, no backpressure. q comes straight from a flop.
//
// Ports:
//   clk_in   : pixel clock
//   rst_n_in : asynchronous active-low reset
//   tmds     : slave side of smoldvi_tmds_encoder_if (den, data, c in; q out)
// ---------------------------------------------------------------------------
module smoldvi_tmds_encoder (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    smoldvi_tmds_encoder_if.slave        tmds
);

    // -----------------------------------------------------------------------
    // Stage 1: transition minimisation
    // -----------------------------------------------------------------------
    logic [3:0] n1d;
    logic       use_xnor;
    logic [7:0] qm_chain;
    logic [8:0] qm_next;

    always_comb begin
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, tmds.data[i]};
        end
    end

    // A tie at four ones is broken by data[0] so the choice is deterministic.
    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !tmds.data[0]);

    assign qm_chain[0] = tmds.data[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_chain
            assign qm_chain[gi] = use_xnor ? ~(qm_chain[gi-1] ^ tmds.data[gi])
                                           :  (qm_chain[gi-1] ^ tmds.data[gi]);
        end
    endgenerate

    assign qm_next = {~use_xnor, qm_chain};

    logic [8:0] qm_reg;
    logic       den_reg;
    logic [1:0] c_reg;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            qm_reg  <= 9'd0;
            den_reg <= 1'b0;
            c_reg   <= 2'b00;
        end else begin
            qm_reg  <= qm_next;
            den_reg <= tmds.den;
            c_reg   <= tmds.c;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: DC balance
    // -----------------------------------------------------------------------
    logic [3:0]        n1;
    logic signed [5:0] disp;       // N1 - N0 = 2*N1 - 8, range -8..+8
    logic signed [5:0] cnt_ext;
    logic signed [5:0] two_qm8;    // 2*qm[8]
    logic signed [5:0] two_nqm8;   // 2*(~qm[8])
    logic signed [5:0] cnt_sum;
    logic signed [4:0] cnt_reg;
    logic signed [4:0] cnt_next;
    logic [9:0]        q_reg;
    logic [9:0]        q_next;
    logic              cnt_pos;
    logic              cnt_neg;
    logic              cnt_zero;

    always_comb begin
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, qm_reg[i]};
        end
    end

    assign disp     = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    assign cnt_ext  = {cnt_reg[4], cnt_reg};
    assign two_qm8  = qm_reg[8] ? 6'sd2 : 6'sd0;
    assign two_nqm8 = qm_reg[8] ? 6'sd0 : 6'sd2;
    assign cnt_zero = (cnt_reg == 5'sd0);
    assign cnt_neg  = cnt_reg[4];
    assign cnt_pos  = !cnt_neg && !cnt_zero;

    always_comb begin
        q_next   = q_reg;
        cnt_sum  = cnt_ext;
        if (!den_reg) begin
            // Blanking: fixed control symbols, disparity restarts from zero.
            cnt_sum = 6'sd0;
            unique case (c_reg)
                2'b00:   q_next = 10'h354;
                2'b01:   q_next = 10'h0AB;
                2'b10:   q_next = 10'h154;
                default: q_next = 10'h2AB;
            endcase
        end else if (cnt_zero || (disp == 6'sd0)) begin
            q_next  = {~qm_reg[8], qm_reg[8],
                       qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
            cnt_sum = qm_reg[8] ? (cnt_ext + disp) : (cnt_ext - disp);
        end else if ((cnt_pos && (disp > 6'sd0)) || (cnt_neg && (disp < 6'sd0))) begin
            // Invert to pull the running disparity back towards zero.
            q_next  = {1'b1, qm_reg[8], ~qm_reg[7:0]};
            cnt_sum = cnt_ext + two_qm8 - disp;
        end else begin
            q_next  = {1'b0, qm_reg[8], qm_reg[7:0]};
            cnt_sum = cnt_ext + disp - two_nqm8;
        end
    end

    // Range is bounded to -10..+10, so dropping the top bit is lossless.
    assign cnt_next = cnt_sum[4:0];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_reg   <= 10'h354;
            cnt_reg <= 5'sd0;
        end else begin
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign tmds.q = q_reg;

endmodule

// File: tb/tb_smoldvi_tmds_encoder.sv
// ---------------------------------------------------------------------------
// tb_smoldvi_tmds_encoder
//
// Directed and randomised checks of the TMDS channel encoder. Inputs are
// driven on the falling edge; q is sampled on the falling edge, where the
// symbol for inputs applied k falling edges earlier is visible at k = 2.
// ---------------------------------------------------------------------------
module tb_smoldvi_tmds_encoder;

    logic clk_in;
    logic rst_n_in;
    int   total;
    int   bad;

    smoldvi_tmds_encoder_if tmds ();

    smoldvi_tmds_encoder dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .tmds     (tmds)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural reference for one symbol, written from the encoding rules.
    function automatic logic [9:0] ref_encode(input logic den, input logic [7:0] d,
                                              input logic [1:0] c, input int cnt_in,
                                              output int cnt_out);
        logic [7:0] qm;
        logic       qm8;
        logic       xn;
        int         n1d;
        int         n1;
        int         n0;
        logic [9:0] sym;
        if (!den) begin
            cnt_out = 0;
            case (c)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            return sym;
        end
        n1d = $countones(d);
        xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm8 = !xn;
        n1 = $countones(qm);
        n0 = 8 - n1;
        if (cnt_in == 0 || n1 == n0) begin
            sym     = {~qm8, qm8, qm8 ? qm : ~qm};
            cnt_out = cnt_in + (qm8 ? (n1 - n0) : (n0 - n1));
        end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
            sym     = {1'b1, qm8, ~qm};
            cnt_out = cnt_in + (qm8 ? 2 : 0) + n0 - n1;
        end else begin
            sym     = {1'b0, qm8, qm};
            cnt_out = cnt_in + n1 - n0 - (qm8 ? 0 : 2);
        end
        return sym;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] sym);
        logic [7:0] qm;
        logic [7:0] d;
        qm = sym[9] ? ~sym[7:0] : sym[7:0];
        d[0] = qm[0];
        for (int i = 1; i < 8; i++) d[i] = sym[8] ? (qm[i] ^ qm[i-1]) : ~(qm[i] ^ qm[i-1]);
        return d;
    endfunction

    task automatic set_idle();
        tmds.den  = 1'b0;
        tmds.data = 8'h00;
        tmds.c    = 2'b00;
    endtask

    // Flush with control cycles so the DUT disparity is back at zero.
    task automatic flush();
        set_idle();
        repeat (3) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        set_idle();
        repeat (3) @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h354) begin
            bad++;
            $display("FAIL reset_hold: q=%h expected=%h", tmds.q, 10'h354);
        end
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            total++;
            if (tmds.q !== 10'h354) begin
                bad++;
                $display("FAIL reset_release[%0d]: q=%h expected=%h", i, tmds.q, 10'h354);
            end
        end
    endtask

    task automatic test_control();
        logic [1:0] cv [3];
        logic [9:0] ex [3];
        cv[0] = 2'b01; ex[0] = 10'h0AB;
        cv[1] = 2'b10; ex[1] = 10'h154;
        cv[2] = 2'b11; ex[2] = 10'h2AB;
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) begin
                tmds.den = 1'b0; tmds.data = 8'hA5; tmds.c = cv[i];
            end else set_idle();
            @(negedge clk_in);
            if (i >= 1) begin
                total++;
                if (tmds.q !== ex[i-1]) begin
                    bad++;
                    $display("FAIL control[%0d]: q=%h expected=%h", i-1, tmds.q, ex[i-1]);
                end
            end
        end
        @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h354) begin
            bad++;
            $display("FAIL control_idle: q=%h expected=%h", tmds.q, 10'h354);
        end
        flush();
    endtask

    task automatic test_disparity_walk();
        logic [9:0] ex [3];
        ex[0] = 10'h100; ex[1] = 10'h3FF; ex[2] = 10'h100;
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) begin
                tmds.den = 1'b1; tmds.data = 8'h00; tmds.c = 2'b00;
            end else set_idle();
            @(negedge clk_in);
            if (i >= 1) begin
                total++;
                if (tmds.q !== ex[i-1]) begin
                    bad++;
                    $display("FAIL walk[%0d]: q=%h expected=%h", i-1, tmds.q, ex[i-1]);
                end
            end
        end
        flush();
    endtask

    task automatic test_xnor();
        tmds.den = 1'b1; tmds.data = 8'hFF; tmds.c = 2'b00;
        @(negedge clk_in);
        set_idle();
        @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h200) begin
            bad++;
            $display("FAIL xnor_ff: q=%h expected=%h", tmds.q, 10'h200);
        end
        flush();
    endtask

    task automatic test_control_clears();
        logic [10:0] vec [3];
        logic [9:0]  ex [3];
        vec[0] = {1'b1, 8'h00, 2'b00}; ex[0] = 10'h100;
        vec[1] = {1'b0, 8'h00, 2'b00}; ex[1] = 10'h354;
        vec[2] = {1'b1, 8'h00, 2'b00}; ex[2] = 10'h100;
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) {tmds.den, tmds.data, tmds.c} = vec[i];
            else set_idle();
            @(negedge clk_in);
            if (i >= 1) begin
                total++;
                if (tmds.q !== ex[i-1]) begin
                    bad++;
                    $display("FAIL ctl_clears[%0d]: q=%h expected=%h", i-1, tmds.q, ex[i-1]);
                end
            end
        end
        flush();
    endtask

    task automatic test_midstream_reset();
        tmds.den = 1'b1; tmds.data = 8'h00; tmds.c = 2'b00;
        repeat (2) @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h100) begin
            bad++;
            $display("FAIL mid_pre: q=%h expected=%h", tmds.q, 10'h100);
        end
        #2 rst_n_in = 1'b0;
        #1;
        total++;
        if (tmds.q !== 10'h354) begin
            bad++;
            $display("FAIL mid_async: q=%h expected=%h", tmds.q, 10'h354);
        end
        @(negedge clk_in);
        set_idle();
        rst_n_in = 1'b1;
        @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h354) begin
            bad++;
            $display("FAIL mid_rel0: q=%h expected=%h", tmds.q, 10'h354);
        end
        tmds.den = 1'b1; tmds.data = 8'h00;
        @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h354) begin
            bad++;
            $display("FAIL mid_rel1: q=%h expected=%h", tmds.q, 10'h354);
        end
        set_idle();
        @(negedge clk_in);
        total++;
        if (tmds.q !== 10'h100) begin
            bad++;
            $display("FAIL mid_first_data: q=%h expected=%h", tmds.q, 10'h100);
        end
        flush();
    endtask

    task automatic test_random();
        localparam int N = 3000;
        logic       rd [N];
        logic [7:0] rdat [N];
        logic [1:0] rc [N];
        logic [9:0] ex [N];
        int         cnt;
        int         cnt_n;
        int         idx;
        int         len;
        logic       mode;
        idx = 0;
        while (idx < N) begin
            mode = ($urandom_range(0, 3) != 0);
            len  = mode ? $urandom_range(1, 40) : $urandom_range(1, 6);
            for (int k = 0; k < len && idx < N; k++) begin
                rd[idx]   = mode;
                rdat[idx] = 8'($urandom);
                rc[idx]   = 2'($urandom);
                idx++;
            end
        end
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            ex[i] = ref_encode(rd[i], rdat[i], rc[i], cnt, cnt_n);
            cnt = cnt_n;
            total++;
            if (cnt > 10 || cnt < -10) begin
                bad++;
                $display("FAIL rand_cnt_range[%0d]: cnt=%0d expected=|cnt|<=10", i, cnt);
            end
        end
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                tmds.den = rd[i]; tmds.data = rdat[i]; tmds.c = rc[i];
            end else set_idle();
            @(negedge clk_in);
            if (i >= 1) begin
                total++;
                if (tmds.q !== ex[i-1]) begin
                    bad++;
                    $display("FAIL rand_q[%0d]: q=%h expected=%h", i-1, tmds.q, ex[i-1]);
                end
                if (rd[i-1]) begin
                    total++;
                    if (decode(tmds.q) !== rdat[i-1]) begin
                        bad++;
                        $display("FAIL rand_decode[%0d]: decoded=%h expected=%h",
                                 i-1, decode(tmds.q), rdat[i-1]);
                    end
                end
            end
        end
        flush();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_control();
        test_disparity_walk();
        test_xnor();
        test_control_clears();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
